// File: rtl/barrel_pkg.sv
// barrel_pkg: shift mode encoding and legality check shared by the barrel shifter
package barrel_pkg;
  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_e;
  function automatic logic is_legal_mode(logic [2:0] m);
    return m <= 3'(ROR);
  endfunction
endpackage

// File: rtl/shift_level.sv
// shift_level: combinational shift/rotate by 2^K, pass-through when disabled or mode is illegal
module shift_level
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K = 0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] dout
);
  localparam int S = 1 << K;
  logic [WIDTH-1:0] sll, srl, sra, rol, ror;
  assign sll = din << S;
  assign srl = din >> S;
  assign sra = $unsigned($signed(din) >>> S);
  assign rol = (din << S) | (din >> (WIDTH - S));
  assign ror = (din >> S) | (din << (WIDTH - S));
  always_comb begin
    dout = din;
    if (en)
      dout = mode == SLL ? sll :
             mode == SRL ? srl :
             mode == SRA ? sra :
             mode == ROL ? rol :
             mode == ROR ? ror : din;
  end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: L-level shift/rotate pipeline with valid/ready flow control
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int L = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [L-1:0]     shamt_i,
  input  logic [2:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);
  logic             adv;
  logic [WIDTH-1:0] d_in [L];
  logic [WIDTH-1:0] d_sh [L];
  logic [WIDTH-1:0] d_q  [L];
  logic [L-1:0]     sh_in [L];
  logic [L-1:0]     sh_q  [L];
  logic [2:0]       md_in [L];
  logic [2:0]       md_q  [L];
  logic             er_in [L];
  logic             er_q  [L];
  logic             vl_in [L];
  logic             vl_q  [L];
  assign adv         = !out_valid_o || out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = vl_q[L-1];
  assign data_o      = d_q[L-1];
  assign err_o       = er_q[L-1];
  for (genvar k = 0; k < L; k++) begin : g_stage
    if (k == 0) begin : g_head
      // illegal modes enter as zero so every later level keeps them zero
      assign d_in[k]  = is_legal_mode(mode_i) ? data_i : '0;
      assign sh_in[k] = shamt_i;
      assign md_in[k] = mode_i;
      assign er_in[k] = !is_legal_mode(mode_i);
      assign vl_in[k] = in_valid_i;
    end else begin : g_tail
      assign d_in[k]  = d_q[k-1];
      assign sh_in[k] = sh_q[k-1];
      assign md_in[k] = md_q[k-1];
      assign er_in[k] = er_q[k-1];
      assign vl_in[k] = vl_q[k-1];
    end
    shift_level #(.WIDTH(WIDTH), .K(k)) u_level (
      .din  (d_in[k]),
      .en   (sh_in[k][k]),
      .mode (md_in[k]),
      .dout (d_sh[k])
    );
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        d_q[k]  <= '0;
        sh_q[k] <= '0;
        md_q[k] <= '0;
        er_q[k] <= 1'b0;
        vl_q[k] <= 1'b0;
      end else if (adv) begin
        d_q[k]  <= d_sh[k];
        sh_q[k] <= sh_in[k];
        md_q[k] <= md_in[k];
        er_q[k] <= er_in[k];
        vl_q[k] <= vl_in[k];
      end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench with directed and random beats at WIDTH=8
module tb_pipelined_barrel_shifter;
  localparam int W = 8;
  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] data = '0;
  logic [2:0]   shamt = '0;
  logic [2:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] data_o;
  logic         err_o;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_chk = 0;
  bit rnd_rdy = 0;
  typedef struct {
    logic [W-1:0] d;
    logic         e;
    int           acc;
  } exp_t;
  exp_t sb[$];

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data),
    .shamt_i     (shamt),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: integer arithmetic on the 8-bit operand, {err, data}
  function automatic logic [W:0] model(logic [W-1:0] d, int sh, int m);
    int v = int'(d);
    int s;
    int r;
    case (m)
      0: r = v << sh;
      1: r = v >> sh;
      2: begin s = d[W-1] ? v - 256 : v; r = s >>> sh; end
      3: r = (v << sh) | (v >> (W - sh));
      4: r = (v >> sh) | (v << (W - sh));
      default: return {1'b1, 8'h00};
    endcase
    return {1'b0, 8'(r & 255)};
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [2:0] sh, input logic [2:0] m,
                      input logic [W-1:0] ed, input logic ee);
    int n = 0;
    int a;
    bit acc = 0;
    data = d;
    shamt = sh;
    mode = m;
    in_valid = 1;
    while (!acc) begin
      #4;
      acc = in_ready;
      a = cyc;
      @(posedge clk);
      if (acc) sb.push_back('{ed, ee, a});
      @(negedge clk);
      n++;
      if (!acc && n > 100) begin
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %b, required 1 within 100 cycles", in_ready);
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic send_m(input logic [W-1:0] d, input logic [2:0] sh, input logic [2:0] m);
    logic [W:0] r;
    r = model(d, int'(sh), int'(m));
    send(d, sh, m, r[W-1:0], r[W]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitor: pops and compares on every output handshake
  initial begin
    logic [W-1:0] prev_d;
    logic prev_e;
    bit stalled;
    exp_t e;
    stalled = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        stalled = 0;
        continue;
      end
      if (stalled) begin
        checks++;
        if (!out_valid || data_o !== prev_d || err_o !== prev_e) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%h e=%b, required v=1 d=%h e=%b",
                   out_valid, data_o, err_o, prev_d, prev_e);
        end
      end
      stalled = out_valid && !out_ready;
      prev_d = data_o;
      prev_e = err_o;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h e=%b, required no beat", data_o, err_o);
        end else begin
          e = sb.pop_front();
          if (data_o !== e.d || err_o !== e.e) begin
            errors++;
            $display("FAIL result: got d=%h e=%b, required d=%h e=%b", data_o, err_o, e.d, e.e);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - e.acc != 3) begin
              errors++;
              $display("FAIL latency: got %0d cycles, required 3", cyc - e.acc);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) if (rnd_rdy) out_ready = ($urandom % 4) != 0;

  initial begin
    #1;
    chk("reset_valid", 8'(out_valid), 8'h00);
    chk("reset_data", data_o, 8'h00);
    chk("reset_err", 8'(err_o), 8'h00);
    @(negedge clk);
    rst = 0;
    chk("ready_after_reset", 8'(in_ready), 8'h01);
    lat_chk = 1;
    send(8'h81, 3'd1, 3'd0, 8'h02, 1'b0);
    wait_drain();
    send(8'h80, 3'd3, 3'd2, 8'hF0, 1'b0);
    send(8'h80, 3'd3, 3'd1, 8'h10, 1'b0);
    send(8'h01, 3'd1, 3'd4, 8'h80, 1'b0);
    send(8'h80, 3'd1, 3'd3, 8'h01, 1'b0);
    for (int m = 0; m < 5; m++) begin
      logic [W-1:0] d;
      d = 8'($urandom);
      send(d, 3'd0, 3'(m), d, 1'b0);
    end
    wait_drain();
    for (int s = 0; s < 8; s++) send(8'h01, 3'(s), 3'd0, 8'h01 << s, 1'b0);
    wait_drain();
    lat_chk = 0;
    send(8'hFF, 3'd5, 3'd6, 8'h00, 1'b1);
    wait_drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) send_m(8'($urandom), 3'($urandom), 3'($urandom_range(0, 4)));
    fork
      send_m(8'hA5, 3'd2, 3'd4);
      begin
        for (int i = 0; i < 5; i++) begin
          #4;
          chk("stall_in_ready", 8'(in_ready), 8'h00);
          chk("stall_out_valid", 8'(out_valid), 8'h01);
          @(negedge clk);
        end
        out_ready = 1;
      end
    join
    wait_drain();
    for (int i = 0; i < 3; i++) send_m(8'($urandom), 3'($urandom), 3'($urandom_range(0, 4)));
    #2;
    rst = 1;
    #1;
    chk("rst_valid", 8'(out_valid), 8'h00);
    chk("rst_data", data_o, 8'h00);
    chk("rst_err", 8'(err_o), 8'h00);
    sb.delete();
    @(negedge clk);
    out_ready = 0;
    @(negedge clk);
    #2;
    rst = 0;
    #2;
    chk("post_rst_ready", 8'(in_ready), 8'h01);
    chk("post_rst_valid", 8'(out_valid), 8'h00);
    @(negedge clk);
    out_ready = 1;
    repeat (6) @(negedge clk);
    rnd_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) @(negedge clk);
      else send_m(8'($urandom), 3'($urandom), 3'($urandom));
    end
    rnd_rdy = 0;
    out_ready = 1;
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits; power of two, >= 2.
REQ-002 The block SHALL have parameter L, default $clog2(WIDTH): number of shift levels, which equals the pipeline latency. L is derived and SHALL NOT be overridden.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous and active-high.
REQ-005 in_valid_i  input  1  input beat valid.
REQ-006 in_ready_o  output  1  block accepts the input beat this cycle.
REQ-007 data_i  input  WIDTH  operand.
REQ-008 shamt_i  input  L  shift amount, range 0..WIDTH-1.
REQ-009 mode_i  input  3  operation, encoded as shift_mode_e.
REQ-010 out_valid_o  output  1  result beat valid.
REQ-011 out_ready_i  input  1  downstream accepts the result beat.
REQ-012 data_o  output  WIDTH  shifted result.
REQ-013 err_o  output  1  result came from an illegal mode code.

Function
REQ-014 Mode encodings SHALL be: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4. Codes 5..7 are illegal.
REQ-015 Shift semantics SHALL be as follows.
- SLL and SRL fill vacated bits with zeros.
- SRA fills vacated bits with data_i[WIDTH-1].
- ROL and ROR wrap bits around.
- shamt_i = 0 passes data_i through unchanged for every legal mode.
REQ-016 The datapath SHALL be L cascaded levels. Level k shifts by 2^k when shamt bit k = 1, and passes the data unchanged otherwise.
REQ-017 A pipeline register SHALL follow every level. Each register holds data, the remaining shamt bits, mode, err and valid.
REQ-018 Latency SHALL be exactly L cycles from input handshake (in_valid_i & in_ready_o) to out_valid_o, absent stalls.
REQ-019 The pipeline SHALL advance on the internal signal adv = !out_valid_o || out_ready_i. When adv = 0, all stage registers hold.
REQ-020 in_ready_o SHALL equal adv, combinationally.
REQ-021 When adv = 1 and in_valid_i = 0, a bubble SHALL enter stage 0. Bubbles propagate and are not collapsed.
REQ-022 While out_valid_o = 1 and out_ready_i = 0, data_o and err_o SHALL remain stable.
REQ-023 An illegal mode SHALL produce data_o = 0 and err_o = 1 with the same latency. Legal modes produce err_o = 0.
REQ-024 Simultaneous input acceptance and output drain in one cycle SHALL be supported with no loss, giving a throughput of 1 beat/cycle.
REQ-025 data_o and err_o SHALL be driven directly from the final stage register, with no combinational path from the inputs.

Reset
REQ-026 Asserting rst_i SHALL immediately clear every stage valid bit.
REQ-027 While rst_i is asserted, out_valid_o = 0, data_o = 0 and err_o = 0.
REQ-028 While rst_i is asserted, stage data, shamt and mode SHALL be 0.
REQ-029 Beats in flight when rst_i asserts SHALL be discarded, with no partial output.
REQ-030 After rst_i deasserts, in_ready_o SHALL be 1, because out_valid_o = 0.

Structure
REQ-031 Package barrel_pkg SHALL hold typedef shift_mode_e (3-bit enum, REQ-014) and a function is_legal_mode().
REQ-032 Each level SHALL be an instance of sub-module shift_level, parameters WIDTH and K.
- shift_level is purely combinational.
- It shifts by 2^K per mode when its enable is 1.
REQ-033 The stage registers SHALL reside in pipelined_barrel_shifter, with one generate loop over L.

Verification
REQ-034 The bench SHALL cover the following directed scenarios at WIDTH=8, L=3:
- SLL 0x81, shamt 1 -> 0x02, err 0, 3 cycles after accept.
- SRA 0x80, shamt 3 -> 0xF0; SRL 0x80, shamt 3 -> 0x10.
- ROR 0x01, shamt 1 -> 0x80; ROL 0x80, shamt 1 -> 0x01; shamt 0 in every mode -> data unchanged.
- Back-to-back beats 0x01/SLL/0..7, out_ready_i = 1 -> outputs 0x01, 0x02 .. 0x80 on 8 consecutive cycles.
- Hold out_ready_i = 0 for 5 cycles with a full pipe -> in_ready_o = 0, data_o stable; release -> no beat lost or duplicated.
- Mode 6 with data 0xFF -> data_o = 0x00, err_o = 1; assert rst_i mid-stream -> out_valid_o = 0 the same cycle, no stale beat after release.
